// File: rtl/regfile_bypass.sv
// Two-read, one-write register file feeding the ALU operands, with same-cycle
// write-to-read bypass and a small Z/Ofl flag register captured from the ALU.
module regfile_bypass #(
    parameter int WIDTH = 16,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] read1RegSel,
    input  logic [SEL_W-1:0] read2RegSel,
    input  logic [SEL_W-1:0] writeRegSel,
    input  logic [WIDTH-1:0] writeData,
    input  logic             write,
    input  logic             flagWrite,
    input  logic             aluZ,
    input  logic             aluOfl,
    output logic [WIDTH-1:0] read1Data,
    output logic [WIDTH-1:0] read2Data,
    output logic             flagZ,
    output logic             flagOfl
);

    localparam int NUM_REGS = 2 ** SEL_W;

    logic [WIDTH-1:0] regs [NUM_REGS];
    logic             write_live;
    logic             bypass1;
    logic             bypass2;

    // Each register decodes its own write strobe; R0 is ordinary storage.
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                regs[g] <= '0;
            end else if (write && (writeRegSel == SEL_W'(g))) begin
                regs[g] <= writeData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flagZ   <= 1'b0;
            flagOfl <= 1'b0;
        end else if (flagWrite) begin
            flagZ   <= aluZ;
            flagOfl <= aluOfl;
        end
    end

    // A write being discarded by reset must not leak through the bypass path.
    assign write_live = write && !rst;
    assign bypass1    = write_live && (read1RegSel == writeRegSel);
    assign bypass2    = write_live && (read2RegSel == writeRegSel);

    always_comb begin
        read1Data = regs[read1RegSel];
        read2Data = regs[read2RegSel];
        if (bypass1) begin
            read1Data = writeData;
        end
        if (bypass2) begin
            read2Data = writeData;
        end
    end

endmodule

// File: doc/regfile_bypass.md
# regfile_bypass

General-purpose register file that feeds the A and B operands of the 16-bit ALU in the unpipelined datapath, plus a small flag register that captures the ALU's zero and overflow results. It provides two combinational read ports, one synchronous write port, and write-to-read bypass, so an instruction that reads a register in the same cycle its predecessor's result is being written sees the new value. Reads drive the ALU operand inputs directly. Writeback data and the ALU's Z and Ofl flags come back in from the writeback mux.

## Interface
Parameters:
- WIDTH, 16, data width of each register, of the write data and of the read data.
- SEL_W, 3, register-select width; the number of registers is 2**SEL_W (8 at default).

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, synchronous, active-high reset.
- read1RegSel, input, SEL_W, register index for read port 1 (ALU A operand).
- read2RegSel, input, SEL_W, register index for read port 2 (ALU B operand).
- writeRegSel, input, SEL_W, register index for the write port.
- writeData, input, WIDTH, data to be written.
- write, input, 1, write enable.
- flagWrite, input, 1, enable to capture the ALU flags.
- aluZ, input, 1, zero flag from the ALU.
- aluOfl, input, 1, overflow flag from the ALU.
- read1Data, output, WIDTH, read port 1 data.
- read2Data, output, WIDTH, read port 2 data.
- flagZ, output, 1, stored zero flag.
- flagOfl, output, 1, stored overflow flag.

## Operation
- Storage and reset:
  - Storage is 2**SEL_W registers of WIDTH bits, all general purpose. R0 is not hardwired to zero.
  - On a clock edge with rst=1, every register is cleared to 0x0000 and flagZ/flagOfl are cleared to 0.
  - Reset overrides write and flagWrite in the same cycle.
- Write:
  - On a clock edge with rst=0 and write=1, reg[writeRegSel] <= writeData.
  - No other register changes.
- Read:
  - readNData = reg[readNRegSel], combinationally from stored state.
  - Bypass: when write=1, rst=0 and readNRegSel==writeRegSel, readNData = writeData in the same cycle.
  - Both ports bypass independently. Both may select the same register, with or without bypass.
  - While rst=1, bypass is disabled and reads return the stored (pre-reset) contents.
- Flags:
  - On a clock edge with rst=0 and flagWrite=1, flagZ <= aluZ and flagOfl <= aluOfl.
  - Otherwise the flags hold.
  - The flags have no bypass; they are visible only after the edge.
  - write and flagWrite are independent and may be asserted together.
- Outputs never go X after the first reset edge. The selects are fully decoded, so every index is legal.

## Timing
- Read latency: 0 cycles (purely combinational from the selects, stored state and the bypass inputs).
- Write latency: 1 cycle. Data is visible from stored state after the edge, and through bypass in the issuing cycle.
- Back-to-back writes to the same register: the last edge wins. A read in the second write's cycle returns the second write's data through bypass.
- Write with write=0 and a changing writeRegSel/writeData has no effect and causes no bypass.
- Reset mid-sequence: a write asserted in the rst=1 cycle is discarded. The register reads 0x0000 after the edge.
- Flag capture is 1 cycle. flagWrite held high captures every cycle.
- Output values after reset: read1Data = read2Data = 0x0000 for all selects when write=0; flagZ = flagOfl = 0.

## Test plan
- Reset clear:
  - Stimulus: preload all 8 registers with 0x1111*i, pulse rst for 1 cycle.
  - Required response: every register reads 0x0000 on both ports; flagZ = flagOfl = 0.
- Write then read:
  - Stimulus: write 0xBEEF to R5 at edge n; at cycle n+1 set read1RegSel=5, read2RegSel=5, write=0.
  - Required response: both ports read 0xBEEF; all other registers are unchanged.
- Bypass:
  - Stimulus: R3 holds 0x0001; in a single cycle assert write=1, writeRegSel=3, writeData=0x8000, read1RegSel=3, read2RegSel=2.
  - Required response: read1Data = 0x8000 combinationally in that cycle; read2Data = old R2. After the edge, R3 reads 0x8000.
- Reset priority:
  - Stimulus: assert rst=1, write=1, writeRegSel=7, writeData=0xFFFF, flagWrite=1, aluZ=1, aluOfl=1.
  - Required response: read1Data with sel 7 shows the stored value (no bypass) during the cycle; after the edge R7 = 0x0000 and both flags = 0.
- Flag capture and hold:
  - Stimulus: flagWrite=1 with aluZ=1, aluOfl=0; next cycle flagWrite=0 with aluZ=0, aluOfl=1.
  - Required response: flagZ=1, flagOfl=0 after the first edge, and both hold those values after the second edge.
- Random regression:
  - Stimulus: 10k cycles of random selects, data, write, flagWrite and occasional rst.
  - Required response: both read ports and both flags match a reference model every cycle.
